msrv32_trap_controller: RTL and testbench
=========================================

Name: msrv32_trap_controller

Overview:
Machine-mode trap sequencer for the RV32I core. It sits between decode/execute and the CSR file. It detects exceptions, enabled interrupts and MRET, then runs a small FSM. The FSM drives the CSR file's cause/EPC/MIE update strobes, selects the next-PC source and flushes the pipeline.

Parameters:
RESET_HOLD_CYCLES, 1, cycles spent in RESET after rst_in deasserts before fetch starts (1..15).

Ports:
clk_in  input  1  core clock
rst_in  input  1  reset, asynchronous, active-high
stall_in  input  1  pipeline stall; holds OPERATING decisions
illegal_instr_in  input  1  decode flagged illegal opcode
misaligned_instr_in  input  1  branch/jump target not word aligned
misaligned_load_in  input  1  load address misaligned
misaligned_store_in  input  1  store address misaligned
ecall_in  input  1  ECALL decoded
ebreak_in  input  1  EBREAK decoded
mret_in  input  1  MRET decoded
mie_in  input  1  mstatus.MIE from CSR file
meie_in, mtie_in, msie_in  input  1 each  interrupt enables from CSR file
meip_in, mtip_in, msip_in  input  1 each  interrupt pending bits from CSR file
i_or_e_out  output  1  1 = interrupt, 0 = exception (to CSR file)
cause_out  output  4  mcause code (to CSR file)
set_cause_out  output  1  write mcause strobe
set_epc_out  output  1  write mepc strobe
mie_clear_out  output  1  save MIE to MPIE, clear MIE
mie_set_out  output  1  restore MIE from MPIE
misaligned_exception_out  output  1  trap is a misaligned exception (mtval selects the faulting address)
instret_inc_out  output  1  minstret increment
pc_src_out  output  2  00 boot, 01 next-PC, 10 mepc, 11 trap vector
flush_out  output  1  kill the instruction in flight
state_out  output  2  00 RESET, 01 OPERATING, 10 TRAP_TAKEN, 11 TRAP_RETURN (debug)

Behaviour:
- Reset (asynchronous, any time, including mid-trap):
  - state goes to RESET and the hold counter loads RESET_HOLD_CYCLES.
  - cause and i_or_e registers clear to 0; the misaligned flag clears.
  - all strobes are 0; pc_src_out = 00; flush_out = 0.
- RESET state:
  - the counter decrements each clock; when it reaches 0 the next state is OPERATING.
  - pc_src_out = 00 for the whole state; no strobes.
- OPERATING state:
  - pc_src_out = 01.
  - trap_req is exception OR interrupt:
    - exception = OR of the six exception inputs.
    - interrupt = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
  - If stall_in = 1, no decision is taken and state holds; instret_inc_out = 0.
  - Else if trap_req:
    - latch cause, i_or_e and the misaligned flag; next state TRAP_TAKEN.
    - instret_inc_out = 0.
  - Else if mret_in: next state TRAP_RETURN; instret_inc_out = 1.
  - Else: instret_inc_out = 1.
  - Exception priority, highest first:
    - misaligned_instr = 0
    - illegal = 2
    - ebreak = 3
    - ecall = 11
    - misaligned_load = 4
    - misaligned_store = 6
  - Interrupt priority, used only when no exception: external 11 > software 3 > timer 7.
  - Exceptions always beat interrupts. A trap request beats MRET in the same cycle.
- TRAP_TAKEN state (exactly 1 cycle):
  - set_cause_out = set_epc_out = mie_clear_out = 1.
  - flush_out = 1; pc_src_out = 11.
  - cause_out, i_or_e_out and misaligned_exception_out present the latched values.
  - Next state is OPERATING.
- TRAP_RETURN state (exactly 1 cycle):
  - mie_set_out = 1; flush_out = 1; pc_src_out = 10.
  - Next state is OPERATING.
- cause_out and i_or_e_out hold their last latched value outside TRAP_TAKEN.
- Inputs are sampled only in OPERATING; inputs arriving in other states are ignored.
- Back-to-back traps are allowed. Trap detection in the OPERATING cycle after TRAP_TAKEN is normal, giving at minimum 2-cycle trap spacing. MIE is already cleared by then, so only exceptions can re-trap.

Test Plan:
1. Reset and bring-up: rst_in high for 3 cycles, then low with RESET_HOLD_CYCLES=1 -> pc_src_out=00, all strobes 0, state_out=00 during reset. One clock after deassert, state_out=01 and pc_src_out=01.
2. Illegal instruction: pulse illegal_instr_in in OPERATING -> next cycle state_out=10, cause_out=2, i_or_e_out=0, set_cause/set_epc/mie_clear/flush=1, pc_src_out=11. The cycle after, state_out=01.
3. Priority: assert misaligned_load_in, ecall_in and meip_in+meie_in+mie_in together -> cause_out=11 (ecall), i_or_e_out=0, misaligned_exception_out=0. Then misaligned_load_in alone -> cause_out=4, misaligned_exception_out=1.
4. Interrupt gating: msip=mtip=1 with msie=mtie=1 and mie_in=0 -> no trap, instret_inc_out=1. Raise mie_in -> cause_out=3, i_or_e_out=1.
5. MRET with a simultaneous trap: mret_in alone -> TRAP_RETURN, mie_set_out=1, pc_src_out=10. mret_in together with ebreak_in -> TRAP_TAKEN with cause_out=3, mie_set_out stays 0.
6. Stall and mid-trap reset: stall_in=1 with illegal_instr_in -> state holds 01, instret_inc_out=0. Assert rst_in during TRAP_TAKEN -> outputs clear immediately, before the next clock edge.

Source files
------------

// File: rtl/msrv32_trap_controller_if.sv
// Signal bundle between the trap controller and the decode/execute and CSR logic.
// The slave modport is the controller's view; master is the surrounding core's view.
interface msrv32_trap_controller_if;
  logic       stall_in;
  logic       illegal_instr_in;
  logic       misaligned_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       ecall_in;
  logic       ebreak_in;
  logic       mret_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;
  logic [1:0] pc_src_out;
  logic       flush_out;
  logic [1:0] state_out;

  modport slave (
    input  stall_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, mie_in,
           meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, misaligned_exception_out, instret_inc_out, pc_src_out,
           flush_out, state_out
  );

  modport master (
    output stall_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, mie_in,
           meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, misaligned_exception_out, instret_inc_out, pc_src_out,
           flush_out, state_out
  );
endinterface

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: detects exceptions, enabled interrupts and MRET,
// then drives CSR update strobes, next-PC source and pipeline flush.
module msrv32_trap_controller #(
  parameter int unsigned RESET_HOLD_CYCLES = 1
) (
  input logic clk_in,
  input logic rst_in,
  msrv32_trap_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  state_t     state, next_state;
  logic [3:0] hold_cnt;
  logic [3:0] cause_q, cause_d;
  logic       i_or_e_q, i_or_e_d;
  logic       misaligned_q, misaligned_d;
  logic       exception, interrupt, trap_req, take_trap;

  always_comb begin
    exception = bus.misaligned_instr_in | bus.illegal_instr_in | bus.ebreak_in |
                bus.ecall_in | bus.misaligned_load_in | bus.misaligned_store_in;
    interrupt = bus.mie_in & ((bus.meie_in & bus.meip_in) |
                              (bus.msie_in & bus.msip_in) |
                              (bus.mtie_in & bus.mtip_in));
    trap_req  = exception | interrupt;
    take_trap = (state == OPERATING) & ~bus.stall_in & trap_req;
  end

  // Priority encoder: exceptions first, then external > software > timer.
  always_comb begin
    cause_d      = '0;
    i_or_e_d     = 1'b0;
    misaligned_d = 1'b0;
    if (bus.misaligned_instr_in) begin
      cause_d      = 4'd0;
      misaligned_d = 1'b1;
    end else if (bus.illegal_instr_in) begin
      cause_d = 4'd2;
    end else if (bus.ebreak_in) begin
      cause_d = 4'd3;
    end else if (bus.ecall_in) begin
      cause_d = 4'd11;
    end else if (bus.misaligned_load_in) begin
      cause_d      = 4'd4;
      misaligned_d = 1'b1;
    end else if (bus.misaligned_store_in) begin
      cause_d      = 4'd6;
      misaligned_d = 1'b1;
    end else if (bus.meie_in & bus.meip_in) begin
      cause_d  = 4'd11;
      i_or_e_d = 1'b1;
    end else if (bus.msie_in & bus.msip_in) begin
      cause_d  = 4'd3;
      i_or_e_d = 1'b1;
    end else begin
      cause_d  = 4'd7;
      i_or_e_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= RESET;
      hold_cnt     <= 4'(RESET_HOLD_CYCLES);
      cause_q      <= '0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RESET && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
      if (take_trap) begin
        cause_q      <= cause_d;
        i_or_e_q     <= i_or_e_d;
        misaligned_q <= misaligned_d;
      end
    end
  end

  always_comb begin
    next_state          = state;
    bus.set_cause_out   = 1'b0;
    bus.set_epc_out     = 1'b0;
    bus.mie_clear_out   = 1'b0;
    bus.mie_set_out     = 1'b0;
    bus.instret_inc_out = 1'b0;
    bus.flush_out       = 1'b0;
    bus.pc_src_out      = 2'b00;
    unique case (state)
      RESET: begin
        // Leave on the edge that takes the counter to zero.
        if (hold_cnt <= 4'd1)
          next_state = OPERATING;
      end
      OPERATING: begin
        bus.pc_src_out = 2'b01;
        if (!bus.stall_in) begin
          if (trap_req) begin
            next_state = TRAP_TAKEN;
          end else begin
            bus.instret_inc_out = 1'b1;
            if (bus.mret_in)
              next_state = TRAP_RETURN;
          end
        end
      end
      TRAP_TAKEN: begin
        bus.set_cause_out = 1'b1;
        bus.set_epc_out   = 1'b1;
        bus.mie_clear_out = 1'b1;
        bus.flush_out     = 1'b1;
        bus.pc_src_out    = 2'b11;
        next_state        = OPERATING;
      end
      TRAP_RETURN: begin
        bus.mie_set_out = 1'b1;
        bus.flush_out   = 1'b1;
        bus.pc_src_out  = 2'b10;
        next_state      = OPERATING;
      end
      default: next_state = RESET;
    endcase
  end

  always_comb begin
    bus.cause_out                = cause_q;
    bus.i_or_e_out               = i_or_e_q;
    bus.misaligned_exception_out = misaligned_q;
    bus.state_out                = state;
  end

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Directed bench for the trap controller: reset, priority, gating, MRET, stall
// and asynchronous reset during a trap.
module tb_msrv32_trap_controller;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  msrv32_trap_controller_if bus ();

  msrv32_trap_controller #(.RESET_HOLD_CYCLES(1)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_in            = 1'b0;
    bus.illegal_instr_in    = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    bus.misaligned_load_in  = 1'b0;
    bus.misaligned_store_in = 1'b0;
    bus.ecall_in            = 1'b0;
    bus.ebreak_in           = 1'b0;
    bus.mret_in             = 1'b0;
    bus.mie_in              = 1'b0;
    bus.meie_in             = 1'b0;
    bus.mtie_in             = 1'b0;
    bus.msie_in             = 1'b0;
    bus.meip_in             = 1'b0;
    bus.mtip_in             = 1'b0;
    bus.msip_in             = 1'b0;
  endtask

  // {set_cause, set_epc, mie_clear, mie_set, flush}
  function automatic logic [4:0] strobes();
    return {bus.set_cause_out, bus.set_epc_out, bus.mie_clear_out,
            bus.mie_set_out, bus.flush_out};
  endfunction

  initial begin
    clear_inputs();
    rst_in = 1'b1;

    // Reset and bring-up
    repeat (3) tick();
    check("rst_state", bus.state_out, 2'b00);
    check("rst_pc_src", bus.pc_src_out, 2'b00);
    check("rst_strobes", strobes(), 5'b00000);
    check("rst_cause", bus.cause_out, 4'd0);
    check("rst_instret", bus.instret_inc_out, 1'b0);
    rst_in = 1'b0;
    #1;
    check("hold_state", bus.state_out, 2'b00);
    tick();
    check("op_state", bus.state_out, 2'b01);
    check("op_pc_src", bus.pc_src_out, 2'b01);
    check("op_instret", bus.instret_inc_out, 1'b1);

    // Illegal instruction
    bus.illegal_instr_in = 1'b1;
    #1;
    check("ill_instret", bus.instret_inc_out, 1'b0);
    tick();
    clear_inputs();
    check("ill_state", bus.state_out, 2'b10);
    check("ill_cause", bus.cause_out, 4'd2);
    check("ill_i_or_e", bus.i_or_e_out, 1'b0);
    check("ill_strobes", strobes(), 5'b11101);
    check("ill_pc_src", bus.pc_src_out, 2'b11);
    check("ill_instret", bus.instret_inc_out, 1'b0);
    tick();
    check("ill_back", bus.state_out, 2'b01);

    // Priority: ecall beats misaligned load and external interrupt
    bus.misaligned_load_in = 1'b1;
    bus.ecall_in = 1'b1;
    bus.meip_in = 1'b1; bus.meie_in = 1'b1; bus.mie_in = 1'b1;
    tick();
    clear_inputs();
    check("pri_cause", bus.cause_out, 4'd11);
    check("pri_i_or_e", bus.i_or_e_out, 1'b0);
    check("pri_mis", bus.misaligned_exception_out, 1'b0);
    tick();
    bus.misaligned_load_in = 1'b1;
    tick();
    clear_inputs();
    check("ld_state", bus.state_out, 2'b10);
    check("ld_cause", bus.cause_out, 4'd4);
    check("ld_mis", bus.misaligned_exception_out, 1'b1);
    tick();
    bus.misaligned_instr_in = 1'b1;
    bus.illegal_instr_in = 1'b1;
    bus.misaligned_store_in = 1'b1;
    tick();
    clear_inputs();
    check("mi_cause", bus.cause_out, 4'd0);
    check("mi_mis", bus.misaligned_exception_out, 1'b1);
    tick();
    bus.misaligned_store_in = 1'b1;
    tick();
    clear_inputs();
    check("st_cause", bus.cause_out, 4'd6);
    tick();

    // Interrupt gating by mie_in
    bus.msip_in = 1'b1; bus.mtip_in = 1'b1;
    bus.msie_in = 1'b1; bus.mtie_in = 1'b1;
    #1;
    check("gate_instret", bus.instret_inc_out, 1'b1);
    tick();
    check("gate_state", bus.state_out, 2'b01);
    bus.mie_in = 1'b1;
    tick();
    clear_inputs();
    check("sw_state", bus.state_out, 2'b10);
    check("sw_cause", bus.cause_out, 4'd3);
    check("sw_i_or_e", bus.i_or_e_out, 1'b1);
    tick();
    check("sw_hold_cause", bus.cause_out, 4'd3);
    bus.mie_in = 1'b1; bus.mtie_in = 1'b1; bus.mtip_in = 1'b1;
    tick();
    clear_inputs();
    check("tm_cause", bus.cause_out, 4'd7);
    tick();
    bus.mie_in = 1'b1;
    bus.meie_in = 1'b1; bus.meip_in = 1'b1;
    bus.msie_in = 1'b1; bus.msip_in = 1'b1;
    tick();
    clear_inputs();
    check("ext_cause", bus.cause_out, 4'd11);
    check("ext_i_or_e", bus.i_or_e_out, 1'b1);
    tick();

    // MRET, alone and against a trap
    bus.mret_in = 1'b1;
    #1;
    check("mret_instret", bus.instret_inc_out, 1'b1);
    tick();
    clear_inputs();
    check("mret_state", bus.state_out, 2'b11);
    check("mret_strobes", strobes(), 5'b00011);
    check("mret_pc_src", bus.pc_src_out, 2'b10);
    tick();
    check("mret_back", bus.state_out, 2'b01);
    bus.mret_in = 1'b1;
    bus.ebreak_in = 1'b1;
    tick();
    clear_inputs();
    check("mret_eb_state", bus.state_out, 2'b10);
    check("mret_eb_cause", bus.cause_out, 4'd3);
    check("mret_eb_mie_set", bus.mie_set_out, 1'b0);
    tick();

    // Stall holds decisions
    bus.stall_in = 1'b1;
    bus.illegal_instr_in = 1'b1;
    #1;
    check("stall_instret", bus.instret_inc_out, 1'b0);
    tick();
    check("stall_state", bus.state_out, 2'b01);
    bus.stall_in = 1'b0;
    tick();
    clear_inputs();
    check("unstall_state", bus.state_out, 2'b10);

    // Asynchronous reset mid-trap
    rst_in = 1'b1;
    #1;
    check("arst_state", bus.state_out, 2'b00);
    check("arst_strobes", strobes(), 5'b00000);
    check("arst_pc_src", bus.pc_src_out, 2'b00);
    check("arst_cause", bus.cause_out, 4'd0);
    check("arst_i_or_e", bus.i_or_e_out, 1'b0);
    tick();
    rst_in = 1'b0;
    tick();
    check("arst_recover", bus.state_out, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
